// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT memory controller.
// The stage_done port is added by FFT_MEM_CTRL_STAGE_DONE_EN.
package fft_pkg;
  localparam int LOG2N    = 5;
  localparam int AW       = LOG2N;
  localparam int NB       = 1 << (LOG2N - 1);
  localparam int READ_LAT = 1;
  localparam int BFLY_LAT = 3;
  localparam int L        = READ_LAT + BFLY_LAT;

  localparam int JW = LOG2N - 1;
  localparam int TW = LOG2N - 1;
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
  } wr_slot_t;
endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address and twiddle-index generator for (stage, j).
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [SW-1:0] i_stage,
  input  logic [JW-1:0] i_j,
  output logic [AW-1:0] o_addr_1,
  output logic [AW-1:0] o_addr_2,
  output logic [TW-1:0] o_tw_idx
);
  logic [SW-1:0] w_sh;
  logic [AW-1:0] w_span;
  logic [AW-1:0] w_j;
  logic [AW-1:0] w_low;

  always_comb begin
    w_sh   = SW'(LOG2N - 1) - i_stage;
    w_span = AW'(1) << w_sh;
    w_j    = AW'(i_j);
    w_low  = w_j & (w_span - AW'(1));
    // Insert a zero bit at position w_sh: the upper leg of each butterfly group.
    o_addr_1 = (((w_j >> w_sh) << 1) << w_sh) | w_low;
    o_addr_2 = o_addr_1 + w_span;
    o_tw_idx = TW'(w_low << i_stage);
  end
endmodule

// File: rtl/fft_mem_ctrl.sv
// Ping-pong two-bank memory sequencer for a radix-2 DIF FFT.
// Optional stage_done output enabled by FFT_MEM_CTRL_STAGE_DONE_EN.
module fft_mem_ctrl
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          select,
  output logic          write_enable,
  output logic [AW-1:0] addr_1,
  output logic [AW-1:0] addr_2,
  output logic [AW-1:0] addw_1,
  output logic [AW-1:0] addw_2,
  output logic [TW-1:0] tw_idx,
  output logic [SW-1:0] stage,
  output logic          result_bank
`ifdef FFT_MEM_CTRL_STAGE_DONE_EN
  ,
  output logic          stage_done
`endif
);
  state_t        r_state;
  logic [JW-1:0] r_j;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_stage;
  logic          r_select;
  logic          r_busy;
  logic          r_done;
  logic          r_result_bank;
  logic [AW-1:0] r_addr_1;
  logic [AW-1:0] r_addr_2;
  logic [TW-1:0] r_tw_idx;
  wr_slot_t      r_pipe [L];

  logic [SW-1:0] w_gen_stage;
  logic [JW-1:0] w_gen_j;
  logic [AW-1:0] w_gen_a1;
  logic [AW-1:0] w_gen_a2;
  logic [TW-1:0] w_gen_tw;

  // Addresses are generated for the butterfly issued in the following cycle.
  always_comb begin
    w_gen_stage = r_stage;
    w_gen_j     = r_j + 1'b1;
    case (r_state)
      IDLE: begin
        w_gen_stage = '0;
        w_gen_j     = '0;
      end
      DRAIN: begin
        w_gen_stage = r_stage + 1'b1;
        w_gen_j     = '0;
      end
      default: ;
    endcase
  end

  fft_addr_gen u_addr_gen (
    .i_stage  (w_gen_stage),
    .i_j      (w_gen_j),
    .o_addr_1 (w_gen_a1),
    .o_addr_2 (w_gen_a2),
    .o_tw_idx (w_gen_tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_j           <= '0;
      r_cnt         <= '0;
      r_stage       <= '0;
      r_select      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result_bank <= 1'b0;
      r_addr_1      <= '0;
      r_addr_2      <= '0;
      r_tw_idx      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_stage  <= '0;
            r_j      <= '0;
            r_select <= 1'b0;
            r_addr_1 <= w_gen_a1;
            r_addr_2 <= w_gen_a2;
            r_tw_idx <= w_gen_tw;
          end
        end
        RUN: begin
          if (r_j == JW'(NB - 1)) begin
            r_state <= DRAIN;
            r_j     <= '0;
            r_cnt   <= '0;
          end else begin
            r_j      <= r_j + 1'b1;
            r_addr_1 <= w_gen_a1;
            r_addr_2 <= w_gen_a2;
            r_tw_idx <= w_gen_tw;
          end
        end
        DRAIN: begin
          // After L cycles every write of this stage has left the pipeline.
          if (r_cnt == CW'(L - 1)) begin
            if (r_stage == SW'(LOG2N - 1)) begin
              r_state       <= FINISH;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_result_bank <= ~r_select;
            end else begin
              r_state  <= RUN;
              r_stage  <= r_stage + 1'b1;
              r_select <= ~r_select;
              r_addr_1 <= w_gen_a1;
              r_addr_2 <= w_gen_a2;
              r_tw_idx <= w_gen_tw;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_pipe[gi] <= '0;
          end else begin
            r_pipe[gi].valid <= (r_state == RUN);
            r_pipe[gi].a1    <= r_addr_1;
            r_pipe[gi].a2    <= r_addr_2;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_pipe[gi] <= '0;
          else     r_pipe[gi] <= r_pipe[gi-1];
        end
      end
    end
  endgenerate

`ifdef FFT_MEM_CTRL_STAGE_DONE_EN
  logic r_stage_done;

  // High during the last DRAIN cycle, which carries the stage's final write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stage_done <= 1'b0;
    else     r_stage_done <= (r_state == RUN && r_j == JW'(NB - 1) && L == 1) ||
                             (r_state == DRAIN && int'(r_cnt) == L - 2);
  end

  assign stage_done = r_stage_done;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign select       = r_select;
  assign stage        = r_stage;
  assign result_bank  = r_result_bank;
  assign addr_1       = r_addr_1;
  assign addr_2       = r_addr_2;
  assign tw_idx       = r_tw_idx;
  assign write_enable = r_pipe[L-1].valid;
  assign addw_1       = r_pipe[L-1].a1;
  assign addw_2       = r_pipe[L-1].a2;
endmodule

// File: doc/fft_mem_ctrl.md
Name: fft_mem_ctrl

Overview:
- Sequences the ping-pong two-bank butterfly memory through all stages of a radix-2 DIF FFT.
- Issues one butterfly (two reads) per cycle and computes the twiddle index.
- Delays the write addresses to match the read-plus-butterfly latency.
- Toggles the bank-select between stages once all writes have drained.
- Sits between the top-level FFT sequencer (start/done) and the two-bank memory plus butterfly datapath.

Parameters:
- LOG2N, 5: log2 of FFT size; address width AW = LOG2N; stages = LOG2N; butterflies per stage NB = 2^(LOG2N-1).
- READ_LAT, 1: memory read latency in cycles.
- BFLY_LAT, 3: butterfly pipeline latency in cycles.
- Derived L = READ_LAT + BFLY_LAT: issue-to-write delay.

Ports:
- clk  in  1  clock (single clock domain).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a transform; sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last write of the last stage has completed.
- select  out  1  bank select to memory. 0: read bank A, write bank B. 1: read bank B, write bank A.
- write_enable  out  1  memory write strobe.
- addr_1  out  AW  read address, upper butterfly leg.
- addr_2  out  AW  read address, lower butterfly leg.
- addw_1  out  AW  write address, upper butterfly leg.
- addw_2  out  AW  write address, lower butterfly leg.
- tw_idx  out  LOG2N-1  twiddle ROM index for the issued butterfly.
- stage  out  clog2(LOG2N)  current stage number.
- result_bank  out  1  bank holding the final result: 0=A, 1=B. Valid when done.

Behaviour:
- Reset (async, rst=1) forces, regardless of state:
  - state=IDLE; busy=0, done=0, select=0, write_enable=0.
  - All addresses and tw_idx = 0; stage=0; result_bank=0.
  - Write-delay pipeline cleared (no pending writes).
- States:
  - IDLE: start=1 → RUN; stage=0, j=0, select=0.
  - RUN: issue butterfly j each cycle. At j=NB-1 → DRAIN; j resets to 0.
  - DRAIN: count L cycles.
    - At the end, if stage<LOG2N-1 → RUN; stage+1, select toggles.
    - Else → FINISH.
  - FINISH: one cycle; done=1; result_bank = ~select (the last write bank); → IDLE.
- Address generation in RUN, with s=stage, span=2^(LOG2N-1-s):
  - addr_1 = ((j >> (LOG2N-1-s)) << (LOG2N-s)) | (j mod span).
  - addr_2 = addr_1 + span.
  - tw_idx = (j mod span) << s, truncated to LOG2N-1 bits.
- addr_1, addr_2 and tw_idx are registered outputs, valid in the same cycle the issue is valid.
- Outside RUN, read addresses hold their last value; the datapath ignores them.
- Write path: an L-deep shift register of {valid, addr_1, addr_2}.
  - write_enable, addw_1 and addw_2 come from tap L: exactly L cycles after the matching issue.
  - Every issue produces exactly one write.
- select never changes while any write is pending. The DRAIN length guarantees this.
- Busy duration: LOG2N*(NB+L) cycles, then done pulses. With defaults: 5*(16+4)=100.
- start while busy is ignored. start asserted in the same cycle done pulses is ignored; it is re-sampled in IDLE.
- rst mid-transform aborts immediately. Memory contents are undefined afterwards; the next start restarts from stage 0.
- Boundary cases:
  - j wrap at NB-1.
  - Last stage: span=1, so the legs are adjacent addresses.
  - First stage: span=NB, tw_idx=j.

Optional Feature:
- FFT_MEM_CTRL_STAGE_DONE_EN
  - Defined: adds output port stage_done (1 bit). It pulses for one cycle on the last DRAIN cycle of every stage, including the final one, coincident with that stage's last write.
  - Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared package fft_pkg:
  - LOG2N, AW, NB, READ_LAT, BFLY_LAT, L.
  - State enum {IDLE, RUN, DRAIN, FINISH}.
  - Address/twiddle width constants.
- One natural sub-module: fft_addr_gen. Combinational (stage, j) → (addr_1, addr_2, tw_idx); reused by the twiddle ROM checker.
- Write-delay shift register stays inline.

Test Plan:
- Reset, then start pulse:
  - Cycle after start: busy=1, select=0, stage=0, j=0 → addr_1=0, addr_2=16, tw_idx=0.
  - At j=5: addr 5/21, tw_idx 5.
- Stage 1, j=5 → addr_1=5, addr_2=13, tw_idx=10. Stage 4, j=5 → addr_1=10, addr_2=11, tw_idx=0.
- Write latency: each write_enable fires exactly 4 cycles after its issue, with identical addresses. Exactly 16 writes per stage. select toggles only after the 16th write of the stage.
- Full run:
  - busy for 100 cycles, then done=1 for one cycle; result_bank=1 (bank B); back in IDLE.
  - Golden-model FFT check on a 32-point impulse → all outputs 1.
- start pulsed at cycle 30 of a run → ignored, total still 100 cycles. rst at cycle 45 → outputs zero immediately, no further write_enable. A new start then completes in 100 cycles.
- With FFT_MEM_CTRL_STAGE_DONE_EN: stage_done pulses 5 times, at busy-cycles 20, 40, 60, 80, 100. Without the macro: build has no stage_done port.
